ps2_key_sequencer: RTL and testbench
====================================

PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning system clocks allowed between PS/2 clock falling edges inside a frame.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning key-event FIFO entries; power of two, 2..64.
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 The block SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port ps2_clk  input  1  raw, asynchronous PS/2 device clock.
REQ-006 The block SHALL have port ps2_data  input  1  raw, asynchronous PS/2 device data.
REQ-007 The block SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-008 The block SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-009 The block SHALL have port evt_code  output  8  scan code of the head event.
REQ-010 The block SHALL have port evt_release  output  1  head event is a break (key up).
REQ-011 The block SHALL have port evt_extended  output  1  head event carried the E0 prefix.
REQ-012 The block SHALL have port frame_err  output  1  one-cycle pulse on start, parity, stop or timeout error.
REQ-013 The block SHALL have port overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-015 Synced ps2_data SHALL be sampled only in the cycle a falling edge is detected.
REQ-016 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: sampled 0 -> DATA with bit counter 0; sampled 1 -> stay IDLE and pulse frame_err.
REQ-018 DATA: 8 bits shifted LSB first; after the bit at count 7 -> PARITY.
REQ-019 PARITY: the 9 bits (data + parity) SHALL have odd parity; a mismatch is recorded and the FSM goes to STOP.
REQ-020 STOP: sampled 1 with no parity error -> byte valid; otherwise frame_err; IDLE in both cases.
REQ-021 For a valid byte, 0xE0 SHALL set the ext flag and 0xF0 the rel flag, with no event pushed.
REQ-022 Any other valid byte SHALL push event {ext, rel, code} and clear both flags.
REQ-023 Every frame error SHALL clear both prefix flags.
REQ-024 Latency: stop bit sampled in cycle N -> FIFO write at end of cycle N+1 -> evt_valid high in cycle N+2 if the FIFO was empty.
REQ-025 Pop SHALL occur when evt_valid and evt_ready are both 1 in a cycle.
REQ-026 evt_code, evt_release and evt_extended SHALL be stable while evt_valid is 1 and evt_ready is 0.
REQ-027 A push to a full FIFO SHALL be accepted only if a pop occurs in the same cycle; otherwise the event is dropped and overflow pulses.
REQ-028 Simultaneous push and pop at any non-empty occupancy SHALL leave occupancy unchanged.
REQ-029 Push and pop SHALL be ignored when empty with no push, so there is no underflow.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.

Reset
REQ-031 Asserting reset_n low SHALL immediately force FSM=IDLE, bit counter=0, flags=0 and FIFO empty.
REQ-032 The same reset SHALL force evt_valid, evt_code, evt_release, evt_extended, frame_err and overflow to 0.
REQ-033 Synchronizer flops SHALL reset to 1 (idle bus) so no false edge is seen after release.
REQ-034 Reset mid-frame SHALL discard the partial frame with no frame_err pulse.

Configuration
REQ-035 With PS2_TIMEOUT_EN defined, a counter SHALL clear on every falling edge and run while the FSM is not IDLE.
REQ-036 With PS2_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 SHALL force IDLE, pulse frame_err and clear flags.
REQ-037 Without PS2_TIMEOUT_EN, the timeout counter SHALL not exist and a stalled frame waits indefinitely.

Structure
REQ-038 Package ps2_pkg SHALL hold the FSM state enum, constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0, and packed struct key_evt_t {extended, release, code[7:0]}.
REQ-039 The FIFO SHALL be sub-module ps2_evt_fifo, parameterized by depth and storing key_evt_t.

Verification
REQ-040 Frame 0x1C with good parity -> one event {code=0x1C, rel=0, ext=0}, evt_valid 2 cycles after stop sample.
REQ-041 Byte sequence E0 F0 75 -> single event {code=0x75, rel=1, ext=1}; prefixes produce no events.
REQ-042 Frame 0x1C with flipped parity, then 0x1C valid -> frame_err pulse once, then exactly one event for 0x1C.
REQ-043 evt_ready=0, FIFO_DEPTH+1 make codes -> FIFO fills, last event dropped, overflow pulses once.
REQ-044 evt_ready=0, full FIFO, then evt_ready=1 in the cycle a new event pushes -> event accepted, no overflow.
REQ-045 (PS2_TIMEOUT_EN) 4 data bits then stall TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 keyboard sequencer shared types.
//   ps2_state_e : frame receiver states
//   PS2_EXT_PREFIX / PS2_BRK_PREFIX : scan-code prefix bytes
//   key_evt_t   : one decoded key event as stored in the event FIFO
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  // "release" is a reserved word in SystemVerilog, so the break flag is "rel".
  typedef struct packed {
    logic       extended;
    logic       rel;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Key-event FIFO, DEPTH entries of key_evt_t (DEPTH power of two, 2..64).
//   clk, reset_n : system clock, async active-low reset
//   push, wr_evt : write request and event; accepted when not full or when
//                  a pop happens in the same cycle
//   pop          : read request; ignored when empty
//   rd_evt       : head entry (only meaningful when !empty)
//   empty, full  : occupancy flags
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push,
  input  key_evt_t wr_evt,
  input  logic     pop,
  output key_evt_t rd_evt,
  output logic     empty,
  output logic     full
);

  localparam int AW = $clog2(DEPTH);

  key_evt_t    mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;   // MSB is the wrap bit separating full from empty
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_evt  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_evt;
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, decodes 11-bit
// frames, folds E0/F0 prefixes into flags and queues key events.
//   clk, reset_n            : system clock, async active-low reset
//   ps2_clk, ps2_data       : raw asynchronous PS/2 lines
//   evt_valid/evt_ready     : event handshake, pop when both high
//   evt_code/release/extended : head event fields (0 while empty)
//   frame_err               : 1-cycle pulse on start/parity/stop/timeout error
//   overflow                : 1-cycle pulse when an event is dropped (FIFO full)
// Optional: define PS2_TIMEOUT_EN to abort frames whose PS/2 clock stalls for
// TIMEOUT_CYCLES system clocks.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_release,
  output logic       evt_extended,
  output logic       frame_err,
  output logic       overflow
);

  // Synchronizers reset to 1 (idle bus) so release never fakes a falling edge.
  logic [1:0] clk_sync, dat_sync;
  logic       clk_d, fall, sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_d    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_d    <= clk_sync[1];
    end
  end

  assign fall   = clk_d & ~clk_sync[1];
  assign sample = dat_sync[1];

  ps2_state_e state, state_n;
  logic [2:0] bit_cnt, cnt_n;
  logic [7:0] shreg, sh_n;
  logic       perr, perr_n;
  logic       bv_n, ferr_n, to_hit;

`ifdef PS2_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    to_cnt <= '0;
    else if (fall || state == IDLE)  to_cnt <= '0;
    else                             to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state != IDLE) && (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    perr_n  = perr;
    bv_n    = 1'b0;
    ferr_n  = 1'b0;
    if (to_hit) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!sample) begin
            state_n = DATA;
            cnt_n   = 3'd0;
            perr_n  = 1'b0;
          end else begin
            ferr_n  = 1'b1;
          end
        end
        DATA: begin
          sh_n  = {sample, shreg[7:1]};   // LSB arrives first
          cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          perr_n  = ~(^{sample, shreg});  // odd parity over data + parity bit
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (sample && !perr) bv_n   = 1'b1;
          else                 ferr_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic       byte_vld_q, ferr_q, ovf_q, ext_q, rel_q;
  logic [7:0] byte_q;
  logic       is_ext, is_brk, push, pop, full, empty;
  key_evt_t   wr_evt, head;

  // Byte decode runs one cycle after the stop bit.
  assign is_ext = byte_vld_q && (byte_q == PS2_EXT_PREFIX);
  assign is_brk = byte_vld_q && (byte_q == PS2_BRK_PREFIX);
  assign push   = byte_vld_q && !is_ext && !is_brk;
  assign pop    = evt_valid && evt_ready;
  assign wr_evt = '{extended: ext_q, rel: rel_q, code: byte_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      perr       <= 1'b0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'd0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= cnt_n;
      shreg      <= sh_n;
      perr       <= perr_n;
      byte_vld_q <= bv_n;
      if (bv_n) byte_q <= shreg;
      ferr_q     <= ferr_n;
      ovf_q      <= push && full && !pop;
      if (ferr_n) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end else if (is_ext) begin
        ext_q <= 1'b1;
      end else if (is_brk) begin
        rel_q <= 1'b1;
      end else if (push) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end
    end
  end

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_evt  (wr_evt),
    .pop     (pop),
    .rd_evt  (head),
    .empty   (empty),
    .full    (full)
  );

  // Head fields are forced to 0 while empty so reset leaves the outputs clean.
  assign evt_valid    = ~empty;
  assign evt_code     = empty ? 8'd0 : head.code;
  assign evt_release  = ~empty & head.rel;
  assign evt_extended = ~empty & head.extended;
  assign frame_err    = ferr_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer: expected events are queued when
// frames are sent and compared as the DUT hands them out.
module tb_ps2_key_sequencer;
  import ps2_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 100;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       evt_valid, evt_ready = 1'b1;
  logic [7:0] evt_code;
  logic       evt_release, evt_extended, frame_err, overflow;

  ps2_key_sequencer #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_release  (evt_release),
    .evt_extended (evt_extended),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int         n_vec = 0, n_err = 0;
  int         n_ferr = 0, n_ovf = 0, n_evt = 0, exp_total = 0;
  logic [9:0] sb[$];
  logic       prev_hold = 1'b0;
  logic [10:0] prev_vec = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake, counts pulses,
  // and checks the head is held while stalled.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_hold)
        chk("hold", {evt_valid, evt_extended, evt_release, evt_code}, prev_vec);
      if (evt_valid && evt_ready) begin
        n_evt++;
        if (sb.size() == 0) chk("unexpected_evt", {evt_extended, evt_release, evt_code}, 32'hFFFF);
        else chk("evt", {evt_extended, evt_release, evt_code}, sb.pop_front());
      end
      if (frame_err) n_ferr++;
      if (overflow)  n_ovf++;
      prev_hold = evt_valid && !evt_ready;
      prev_vec  = {evt_valid, evt_extended, evt_release, evt_code};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic set_ready(input logic r);
    @(posedge clk); #1 evt_ready = r;
    @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame. lat = negedges from the stop-bit clock fall until evt_valid
  // is seen (-1 if not within 5); rdy_at raises evt_ready after that posedge.
  task automatic send_frame(input logic [7:0] code, input logic bad_par,
                            input int rdy_at, output int lat);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    lat = -1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == rdy_at) evt_ready = 1'b1;
      @(negedge clk);
      if (evt_valid && lat < 0) lat = i;
    end
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] code);
    int lat;
    send_frame(code, 1'b0, 0, lat);
  endtask

  task automatic key(input logic [7:0] code, input logic ext, input logic rel);
    if (ext) frame(8'hE0);
    if (rel) frame(8'hF0);
    sb.push_back({ext, rel, code});
    exp_total++;
    frame(code);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    int lat, f0, o0;
    repeat (3) @(negedge clk);
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", {evt_extended, evt_release, evt_code}, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // plain make code and its latency from the stop-bit edge
    sb.push_back({2'b00, 8'h1C}); exp_total++;
    send_frame(8'h1C, 1'b0, 0, lat);
    chk("latency", lat, 4);
    wait_drain("drain_1c");

    // prefix folding
    f0 = n_evt;
    key(8'h75, 1'b1, 1'b1);
    wait_drain("drain_e0f075");
    chk("e0f075_count", n_evt - f0, 1);
    key(8'h1C, 1'b0, 1'b1);
    key(8'h6B, 1'b1, 1'b0);
    key(8'h00, 1'b0, 1'b0);
    key(8'hFF, 1'b0, 1'b0);
    wait_drain("drain_mix");

    // parity error, then a good frame
    f0 = n_ferr;
    send_frame(8'h1C, 1'b1, 0, lat);
    chk("par_ferr", n_ferr - f0, 1);
    key(8'h1C, 1'b0, 0);
    wait_drain("drain_par");
    chk("par_ferr_once", n_ferr - f0, 1);

    // start-bit error clears a pending E0 prefix
    f0 = n_ferr;
    frame(8'hE0);
    ps2_bit(1'b1);
    repeat (5) @(negedge clk);
    chk("start_ferr", n_ferr - f0, 1);
    key(8'h1C, 1'b0, 1'b0);
    wait_drain("drain_start");

    // overflow: DEPTH+1 events with consumer stalled
    o0 = n_ovf;
    set_ready(1'b0);
    for (int i = 0; i < DEPTH; i++) key(8'h15 + 8'(i), 1'b0, 1'b0);
    frame(8'h2B);
    repeat (3) @(negedge clk);
    chk("ovf_pulse", n_ovf - o0, 1);
    chk("ovf_valid", evt_valid, 1);
    set_ready(1'b1);
    wait_drain("drain_ovf");

    // full FIFO, pop in the same cycle as the push: nothing dropped
    o0 = n_ovf;
    set_ready(1'b0);
    for (int i = 0; i < DEPTH; i++) key(8'h30 + 8'(i), 1'b0, 1'b0);
    sb.push_back({2'b00, 8'h3C}); exp_total++;
    send_frame(8'h3C, 1'b0, 3, lat);
    wait_drain("drain_simul");
    chk("simul_no_ovf", n_ovf - o0, 0);

    // reset mid-frame discards the partial frame silently
    f0 = n_ferr;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_ferr", frame_err, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    key(8'h2A, 1'b0, 1'b0);
    wait_drain("drain_rst_mid");
    chk("rst_mid_no_ferr", n_ferr - f0, 0);

`ifdef PS2_TIMEOUT_EN
    f0 = n_ferr;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TO + 20) @(negedge clk);
    chk("timeout_ferr", n_ferr - f0, 1);
    key(8'h5A, 1'b0, 1'b0);
    wait_drain("drain_timeout");
`endif

    repeat (10) @(negedge clk);
    chk("evt_total", n_evt, exp_total);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
